dac_tx: RTL and testbench

DAC_TX -- requirements
Module: dac_tx

---
 rtl/dac_tx_pkg.sv | 28 ++
 rtl/dac_tx_piso_shift.sv | 31 +++
 rtl/dac_tx.sv | 163 ++++++++++++++++
 tb/tb_dac_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_pkg.sv
// Shared definitions for the serial DAC transmitter: frame geometry,
// FSM state encoding and the frame-assembly helper.
package dac_tx_pkg;

    // Frame geometry: command nibble followed by the 12-bit sample.
    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CTRL_W     = FRAME_BITS - DATA_BITS;

    // Width of the bit and quiet counters (bit counter spans 15..0).
    localparam int CNT_W = 4;

    // Transmitter states. Code 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_QUIET = 2'b10
    } dac_state_e;

    // Assemble an on-wire frame, command nibble in the MSBs.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [CTRL_W-1:0]    ctrl,
        input logic [DATA_BITS-1:0] data
    );
        return {ctrl, data};
    endfunction

endpackage : dac_tx_pkg

// File: rtl/dac_tx_piso_shift.sv
// 16-bit parallel-in / serial-out shift register. Loads a whole frame,
// then shifts left one bit per enabled edge; the MSB drives sout.
module piso_shift
    import dac_tx_pkg::*;
(
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [FRAME_BITS-1:0] pdata,
    output logic                  sout
);

    logic [FRAME_BITS-1:0] shreg_q;

    // Frame register: load takes priority over shift; zeros fill from the right.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= pdata;
        end else if (shift) begin
            shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign sout = shreg_q[FRAME_BITS-1];

endmodule : piso_shift

// File: rtl/dac_tx.sv
// Serial DAC transmitter. Sends 16-bit frames {CTRL_BITS, din} MSB first
// under an active-low chip select, separates frames by QUIET_CYCLES sclk
// cycles of cs_n high, and buffers one pending sample in a hold register
// so a start arriving mid-frame is launched straight after the gap.
module dac_tx
    import dac_tx_pkg::*;
#(
    parameter logic [CTRL_W-1:0] CTRL_BITS    = 4'b0000,
    parameter int unsigned       QUIET_CYCLES = 2        // legal 1..15
)
(
    input  logic                 sclk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 ready,
    output logic                 busy,
    output logic                 cs_n,
    output logic                 sdout,
    output logic                 done
);

    // State register is plain logic so the unused code 2'b11 is representable
    // and can be steered back to IDLE.
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_QUIET = ST_QUIET;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

    logic [1:0]            state_q,      state_d;
    logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [CNT_W-1:0]      quiet_cnt_q,  quiet_cnt_d;
    logic [FRAME_BITS-1:0] hold_q,       hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  done_q,       done_d;

    logic                  sr_load;
    logic                  sr_shift;
    logic [FRAME_BITS-1:0] sr_pdata;
    logic                  sr_sout;

    logic [FRAME_BITS-1:0] din_frame;
    logic                  accept;

    assign din_frame = build_frame(CTRL_BITS, din);

    // A start is taken only while the hold register is empty.
    assign accept = start & ~hold_valid_q;

    // Next-state logic: frame launch, bit/quiet counting and hold management.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        quiet_cnt_d  = quiet_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_pdata     = din_frame;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    sr_load   = 1'b1;
                    sr_pdata  = din_frame;
                    bit_cnt_d = BIT_LAST;
                end
            end

            S_SHIFT: begin
                // A start during the frame is parked for the next launch.
                if (accept) begin
                    hold_d       = din_frame;
                    hold_valid_d = 1'b1;
                end
                if (bit_cnt_q == '0) begin
                    state_d     = S_QUIET;
                    done_d      = 1'b1;
                    quiet_cnt_d = QUIET_LAST;
                end else begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            S_QUIET: begin
                if (quiet_cnt_q == '0) begin
                    if (hold_valid_q) begin
                        // Held frame goes first; ready rises on this same edge.
                        state_d      = S_SHIFT;
                        sr_load      = 1'b1;
                        sr_pdata     = hold_q;
                        bit_cnt_d    = BIT_LAST;
                        hold_d       = '0;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        state_d   = S_SHIFT;
                        sr_load   = 1'b1;
                        sr_pdata  = din_frame;
                        bit_cnt_d = BIT_LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    quiet_cnt_d = quiet_cnt_q - 1'b1;
                    if (accept) begin
                        hold_d       = din_frame;
                        hold_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any frame and drops the held sample.
    // NOTE: the hold register is reset along with the control flops because a
    // stale held frame must never launch after reset.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            quiet_cnt_q  <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            quiet_cnt_q  <= quiet_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
        end
    end

    piso_shift u_piso_shift (
        .sclk  (sclk),
        .reset (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .pdata (sr_pdata),
        .sout  (sr_sout)
    );

    // Outputs decode straight from the state register, so reset raises cs_n
    // without waiting for an edge.
    assign ready = ~hold_valid_q;
    assign busy  = (state_q != S_IDLE);
    assign cs_n  = (state_q != S_SHIFT);
    assign sdout = (state_q == S_SHIFT) & sr_sout;
    assign done  = done_q;

endmodule : dac_tx

// File: tb/tb_dac_tx.sv
// Directed bench for dac_tx: expected frames are queued when a start is
// driven and compared when a complete frame is seen on cs_n/sdout.
module tb_dac_tx;

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [11:0] din_a = '0, din_b = '0;
    logic        ready_a, busy_a, cs_n_a, sdout_a, done_a;
    logic        ready_b, busy_b, cs_n_b, sdout_b, done_b;

    dac_tx dut_a (
        .sclk  (sclk),
        .reset (reset),
        .start (start_a),
        .din   (din_a),
        .ready (ready_a),
        .busy  (busy_a),
        .cs_n  (cs_n_a),
        .sdout (sdout_a),
        .done  (done_a)
    );

    dac_tx #(.CTRL_BITS(4'b0011), .QUIET_CYCLES(1)) dut_b (
        .sclk  (sclk),
        .reset (reset),
        .start (start_b),
        .din   (din_b),
        .ready (ready_b),
        .busy  (busy_b),
        .cs_n  (cs_n_b),
        .sdout (sdout_b),
        .done  (done_b)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor follows whichever instance sel points at.
    logic sel = 1'b0;
    logic m_cs_n, m_sdout, m_done, m_busy;
    assign m_cs_n  = sel ? cs_n_b  : cs_n_a;
    assign m_sdout = sel ? sdout_b : sdout_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_busy  = sel ? busy_b  : busy_a;

    logic [15:0] sb[$];
    logic [15:0] mon_sh = '0;
    logic [15:0] exp_frame;
    int          bit_cnt = 0;
    bit          pend_done = 1'b0;
    int          gap_cnt = 0, last_gap = 0, gaps_seen = 0, frames_seen = 0;

    always @(negedge sclk) begin
        if (reset) begin
            bit_cnt   = 0;
            pend_done = 1'b0;
            gap_cnt   = 0;
        end else begin
            if (m_done || pend_done)
                chk("done_pulse", 32'(m_done), 32'(pend_done));
            pend_done = 1'b0;
            if (!m_cs_n) begin
                if (gap_cnt != 0) begin
                    last_gap = gap_cnt;
                    gaps_seen++;
                end
                gap_cnt = 0;
                mon_sh  = {mon_sh[14:0], m_sdout};
                bit_cnt++;
                if (bit_cnt == 16) begin
                    frames_seen++;
                    pend_done = 1'b1;
                    bit_cnt   = 0;
                    chk("sb_nonempty", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_frame = sb.pop_front();
                        chk("frame_data", 32'(mon_sh), 32'(exp_frame));
                    end
                end
            end else begin
                if (bit_cnt != 0) begin
                    chk("frame_len", bit_cnt, 16);
                    bit_cnt = 0;
                end
                chk("sdout_cs_high", 32'(m_sdout), 0);
                if (m_busy) gap_cnt++;
                else        gap_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int exp_n);
        int n = 0;
        while ((sel ? busy_b : busy_a) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_cs_n",  32'(cs_n_a),  1);
        chk("rst_sdout", 32'(sdout_a), 0);
        chk("rst_busy",  32'(busy_a),  0);
        chk("rst_ready", 32'(ready_a), 1);
        chk("rst_done",  32'(done_a),  0);
        reset = 1'b0;
        tick();

        // Single frame 0x0A5C, din changed right after acceptance
        din_a = 12'hA5C; start_a = 1'b1; sb.push_back(16'h0A5C);
        tick();
        start_a = 1'b0; din_a = 12'h3C3;
        chk("t1_cs_n_low", 32'(cs_n_a),  0);
        chk("t1_busy",     32'(busy_a),  1);
        chk("t1_ready",    32'(ready_a), 1);
        chk("t1_bit15",    32'(sdout_a), 0);
        wait_idle("t1_busy_cycles", 18);
        chk("t1_cs_n_idle", 32'(cs_n_a), 1);
        chk("t1_frames",    frames_seen, 1);

        // Held second frame, third start ignored while ready=0
        tick();
        din_a = 12'h123; start_a = 1'b1; sb.push_back(16'h0123);
        tick();
        din_a = 12'h456; sb.push_back(16'h0456);
        tick();
        chk("t2_ready_low", 32'(ready_a), 0);
        din_a = 12'h789;
        tick();
        chk("t2_ready_still_low", 32'(ready_a), 0);
        start_a = 1'b0; din_a = '0;
        n = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
        end
        chk("t2_launch_delay", n, 16);
        chk("t2_frame2_cs_n",  32'(cs_n_a), 0);
        chk("t2_frame2_busy",  32'(busy_a), 1);
        wait_idle("t2_idle", 18);
        chk("t2_gap",    last_gap, 2);
        chk("t2_frames", frames_seen, 3);

        // start held high: back-to-back 0x0FFF frames
        tick();
        g0 = gaps_seen;
        din_a = 12'hFFF; start_a = 1'b1;
        repeat (3) sb.push_back(16'h0FFF);
        repeat (37) tick();
        start_a = 1'b0;
        wait_idle("t3_idle", 18);
        chk("t3_gaps",     gaps_seen - g0, 2);
        chk("t3_gap_len",  last_gap, 2);
        chk("t3_frames",   frames_seen, 6);

        // Reset mid-frame with a held sample pending
        tick();
        din_a = 12'hABC; start_a = 1'b1;
        tick();
        din_a = 12'hDDD;
        tick();
        start_a = 1'b0;
        chk("t4_held", 32'(ready_a), 0);
        repeat (6) tick();
        chk("t4_mid_cs_n", 32'(cs_n_a), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_cs_n", 32'(cs_n_a),  1);
        chk("t4_busy",       32'(busy_a),  0);
        chk("t4_ready",      32'(ready_a), 1);
        chk("t4_sdout",      32'(sdout_a), 0);
        chk("t4_done",       32'(done_a),  0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("t4_no_frame", frames_seen, 6);
        din_a = 12'h001; start_a = 1'b1; sb.push_back(16'h0001);
        tick();
        start_a = 1'b0;
        wait_idle("t4_idle", 18);
        chk("t4_frames", frames_seen, 7);

        // Second instance: CTRL_BITS=0011, QUIET_CYCLES=1
        sel = 1'b1;
        tick();
        g0 = gaps_seen;
        din_b = 12'h800; start_b = 1'b1;
        repeat (2) sb.push_back(16'h3800);
        repeat (18) tick();
        start_b = 1'b0;
        wait_idle("t5_idle", 17);
        chk("t5_gaps",    gaps_seen - g0, 1);
        chk("t5_gap_len", last_gap, 1);
        chk("t5_frames",  frames_seen, 9);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dac_tx
